syndrome_detector: RTL and testbench



---
 rtl/syndrome_detector.sv | 151 +++++++++++++++
 tb/tb_syndrome_detector.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/syndrome_detector.sv
// Serial syndrome computation for the (15,7) majority-logic decoder: r(x) mod g(x) via a division LFSR.
// Optional define SYND_CROSSCHECK_EN adds a parallel syndrome and a synd_mismatch flag.
module syndrome_detector #(
  parameter int         N     = 15,
  parameter int         R     = 8,
  parameter logic [8:0] GPOLY = 9'h1D1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] in_cw,
  output logic         in_ready,
  output logic [N-1:0] cw_out,
  output logic [R-1:0] syndrome,
  output logic         done,
  output logic         error
`ifdef SYND_CROSSCHECK_EN
  ,
  output logic         synd_mismatch
`endif
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   sreg_q, sreg_d;
  logic [R-1:0]   lfsr_q, lfsr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   cw_q, cw_d;
  logic [R-1:0]   synd_q, synd_d;
  logic           done_q, done_d;
  logic           error_q, error_d;
  logic           ready_q, ready_d;
  logic [R-1:0]   lfsr_step;

`ifdef SYND_CROSSCHECK_EN
  logic [R-1:0]   par_q, par_d;
  logic           mism_q, mism_d;

  // Column i of H is x^i mod g(x); the syndrome is the XOR of the columns selected by set bits.
  function automatic logic [R-1:0] par_syndrome(input logic [N-1:0] cw);
    logic [R-1:0] col;
    logic [R-1:0] acc;
    col = R'(1);
    acc = '0;
    for (int i = 0; i < N; i++) begin
      if (cw[i]) acc = acc ^ col;
      col = {col[R-2:0], 1'b0} ^ (col[R-1] ? GPOLY[R-1:0] : '0);
    end
    return acc;
  endfunction
`endif

  // One Horner step: multiply the remainder by x, fold x^8 back in as g's low terms, add the next bit.
  assign lfsr_step = {lfsr_q[R-2:0], sreg_q[N-1]} ^ (lfsr_q[R-1] ? GPOLY[R-1:0] : '0);

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    cw_d    = cw_q;
    synd_d  = synd_q;
    done_d  = 1'b0;
    error_d = 1'b0;
`ifdef SYND_CROSSCHECK_EN
    par_d   = par_q;
    mism_d  = mism_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sreg_d  = in_cw;
          cw_d    = in_cw;
          lfsr_d  = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
`ifdef SYND_CROSSCHECK_EN
          par_d   = par_syndrome(in_cw);
          mism_d  = 1'b0;
`endif
        end
      end
      S_SHIFT: begin
        sreg_d = {sreg_q[N-2:0], 1'b0};
        lfsr_d = lfsr_step;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        synd_d  = lfsr_q;
        done_d  = 1'b1;
        error_d = |lfsr_q;
        state_d = S_IDLE;
`ifdef SYND_CROSSCHECK_EN
        mism_d  = (lfsr_q != par_q);
`endif
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      lfsr_q  <= '0;
      cnt_q   <= '0;
      cw_q    <= '0;
      synd_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      ready_q <= 1'b1;
`ifdef SYND_CROSSCHECK_EN
      par_q   <= '0;
      mism_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      cw_q    <= cw_d;
      synd_q  <= synd_d;
      done_q  <= done_d;
      error_q <= error_d;
      ready_q <= ready_d;
`ifdef SYND_CROSSCHECK_EN
      par_q   <= par_d;
      mism_q  <= mism_d;
`endif
    end
  end

  assign in_ready = ready_q;
  assign cw_out   = cw_q;
  assign syndrome = synd_q;
  assign done     = done_q;
  assign error    = error_q;
`ifdef SYND_CROSSCHECK_EN
  assign synd_mismatch = mism_q;
`endif

endmodule

// File: tb/tb_syndrome_detector.sv
// Self-checking bench for syndrome_detector: directed cases, single-bit sweep, handshake/reset cases
// and random words compared against a polynomial long-division model.
module tb_syndrome_detector;

   logic        clk;
   logic        rst;
   logic        inValid;
   logic [14:0] inCw;
   logic        inReady;
   logic [14:0] cwOut;
   logic [7:0]  syndrome;
   logic        done;
   logic        error;
`ifdef SYND_CROSSCHECK_EN
   logic        syndMismatch;
`endif

   int assertCount = 0;
   int failCount   = 0;

   syndrome_detector dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (inValid),
      .in_cw    (inCw),
      .in_ready (inReady),
      .cw_out   (cwOut),
      .syndrome (syndrome),
      .done     (done),
      .error    (error)
`ifdef SYND_CROSSCHECK_EN
      ,
      .synd_mismatch (syndMismatch)
`endif
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: remainder of r(x) by g(x) through plain long division on an integer
   function automatic logic [7:0] modelSyndrome(input logic [14:0] cw);
      logic [31:0] r;
      r = {17'd0, cw};
      for (int i = 14; i >= 8; i--) begin
         if (r[i]) r = r ^ (32'h1D1 << (i - 8));
      end
      return r[7:0];
   endfunction

   // Builds a genuine codeword as the carry-less product m(x) * g(x)
   function automatic logic [14:0] encodeMsg(input logic [6:0] m);
      logic [31:0] p;
      p = 32'd0;
      for (int i = 0; i < 7; i++) begin
         if (m[i]) p = p ^ (32'h1D1 << i);
      end
      return p[14:0];
   endfunction

   // Advance past the next rising edge so outputs are sampled away from it
   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   // Drive the upstream handshake inputs
   task automatic applyStimulus(input logic valid, input logic [14:0] cw);
      inValid = valid;
      inCw    = cw;
   endtask

   // One comparison: counts it, and on a miss counts the failure and reports it
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Counts edges until done rises, giving up after a bounded number of cycles
   task automatic waitDone(output int latency);
      latency = 0;
      do begin
         stepClock();
         latency++;
      end while (!done && latency < 40);
   endtask

   // Full transaction: accept a word, scramble in_cw afterwards, then check result and pulse shape
   task automatic runWord(input logic [14:0] word, input logic [7:0] expSyn, input string tag);
      int latency;
      applyStimulus(1'b1, word);
      checkOutput({tag, ".ready"}, 32'(inReady), 32'd1);
      stepClock();
      applyStimulus(1'b0, word ^ 15'h5A5A);
      checkOutput({tag, ".busy"}, 32'(inReady), 32'd0);
      checkOutput({tag, ".cwAccept"}, 32'(cwOut), 32'(word));
      waitDone(latency);
      checkOutput({tag, ".latency"}, 32'(latency), 32'd16);
      checkOutput({tag, ".syndrome"}, 32'(syndrome), 32'(expSyn));
      checkOutput({tag, ".error"}, 32'(error), 32'(expSyn != 8'h00));
      checkOutput({tag, ".cwOut"}, 32'(cwOut), 32'(word));
`ifdef SYND_CROSSCHECK_EN
      checkOutput({tag, ".mismatch"}, 32'(syndMismatch), 32'd0);
`endif
      stepClock();
      checkOutput({tag, ".donePulse"}, 32'(done), 32'd0);
      checkOutput({tag, ".errorPulse"}, 32'(error), 32'd0);
      checkOutput({tag, ".synHold"}, 32'(syndrome), 32'(expSyn));
   endtask

   // Directed sequence followed by the random sweep
   initial begin
      logic [7:0]  singleBitSyn [15];
      logic [14:0] word;
      logic [14:0] firstWord;
      int          latency;
      logic        sawDone;

      singleBitSyn = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                       8'hD1, 8'h73, 8'hE6, 8'h1D, 8'h3A, 8'h74, 8'hE8};

      // Reset values
      rst = 1'b1;
      applyStimulus(1'b0, 15'h0000);
      repeat (3) stepClock();
      checkOutput("reset.ready", 32'(inReady), 32'd1);
      checkOutput("reset.cwOut", 32'(cwOut), 32'd0);
      checkOutput("reset.syndrome", 32'(syndrome), 32'd0);
      checkOutput("reset.done", 32'(done), 32'd0);
      checkOutput("reset.error", 32'(error), 32'd0);
      rst = 1'b0;
      stepClock();

      // Directed words from the plan
      runWord(15'h0000, 8'h00, "zero");
      runWord(15'h01D1, 8'h00, "gen");
      runWord(15'h41D1, 8'hE8, "genFlip14");

      // Single-bit error sweep against the tabulated x^i mod g values
      for (int i = 0; i < 15; i++) begin
         word = 15'd1 << i;
         runWord(word, singleBitSyn[i], $sformatf("bit%0d", i));
      end

      // Multiples of g(x) must give a zero syndrome
      for (int i = 0; i < 4; i++) begin
         runWord(encodeMsg(7'($urandom)), 8'h00, $sformatf("codeword%0d", i));
      end

      // in_valid held high with in_cw changing mid-shift: second word waits for the idle slot
      firstWord = 15'h1234;
      applyStimulus(1'b1, firstWord);
      stepClock();
      applyStimulus(1'b1, 15'h7FFF);
      checkOutput("hold.busy", 32'(inReady), 32'd0);
      waitDone(latency);
      checkOutput("hold.latency", 32'(latency), 32'd16);
      checkOutput("hold.syndrome", 32'(syndrome), 32'(modelSyndrome(firstWord)));
      checkOutput("hold.cwOut", 32'(cwOut), 32'(firstWord));
      checkOutput("hold.readyAfterDone", 32'(inReady), 32'd1);
      stepClock();
      checkOutput("hold.secondAccept", 32'(cwOut), 32'h7FFF);
      checkOutput("hold.secondBusy", 32'(inReady), 32'd0);
      checkOutput("hold.synKept", 32'(syndrome), 32'(modelSyndrome(firstWord)));
      applyStimulus(1'b0, 15'h0000);
      waitDone(latency);
      checkOutput("hold.secondLatency", 32'(latency), 32'd16);
      checkOutput("hold.secondSyndrome", 32'(syndrome), 32'(modelSyndrome(15'h7FFF)));
      stepClock();

      // Reset in the middle of shifting aborts with no pulse
      runWord(15'h41D1, 8'hE8, "preAbort");
      applyStimulus(1'b1, 15'h41D1);
      stepClock();
      applyStimulus(1'b0, 15'h0000);
      repeat (8) stepClock();
      rst = 1'b1;
      #1;
      checkOutput("abort.ready", 32'(inReady), 32'd1);
      checkOutput("abort.cwOut", 32'(cwOut), 32'd0);
      checkOutput("abort.syndrome", 32'(syndrome), 32'd0);
      checkOutput("abort.done", 32'(done), 32'd0);
      stepClock();
      rst = 1'b0;
      sawDone = 1'b0;
      for (int i = 0; i < 20; i++) begin
         stepClock();
         if (done || error) sawDone = 1'b1;
      end
      checkOutput("abort.noPulse", 32'(sawDone), 32'd0);
      checkOutput("abort.readyAfter", 32'(inReady), 32'd1);

      // Random words against the long-division model
      for (int i = 0; i < 1000; i++) begin
         word = 15'($urandom);
         runWord(word, modelSyndrome(word), $sformatf("rand%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
